// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   DEF_ADDR_W      default instruction address width (word addressed)
//   DEF_INSTR_W     default instruction word width
//   DEF_FIFO_DEPTH  default prefetch depth (power of two, >= 2)
//   DEF_RESET_PC    PC loaded on reset
//   NOP_INSTR       NOP encoding, also what the fetch unit drives on idle data lines
package instr_fetch_unit_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_INSTR_W    = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam logic [DEF_ADDR_W-1:0]  DEF_RESET_PC = 8'h00;
  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR    = 16'h0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, InstructionMemory and decode.
//   imem_*          read port to InstructionMemory (fetch drives address/enable)
//   instr*          valid/ready hand-off of fetched words to decode
//   redirect_*      taken branch/jump request from execute
// Modports: master = fetch unit, slave = memory/decode/execute side.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);

  logic [ADDR_W-1:0]  imem_address;
  logic               imem_rw_enable;
  logic [INSTR_W-1:0] imem_data_in;
  logic [INSTR_W-1:0] imem_data_out;

  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;

  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;

  modport master (
    output imem_address, imem_rw_enable, imem_data_in,
    input  imem_data_out,
    output instr, instr_pc, instr_valid,
    input  instr_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_address, imem_rw_enable, imem_data_in,
    output imem_data_out,
    input  instr, instr_pc, instr_valid,
    output instr_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush.
//   clk, reset   rising-edge clock, synchronous active-high reset
//   flush        discard all entries; dominates push and pop
//   push/push_data  write one entry (ignored when full)
//   pop          remove head (ignored when empty)
//   head         current head entry, read straight from storage
//   count/full/empty  occupancy status
module fetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers are exactly PTR_W bits so they wrap at DEPTH on their own.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty/count gate every read, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage between InstructionMemory and decode.
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears PC, prefetch buffer and in-flight read
//   bus    instr_fetch_unit_if.master:
//            imem_address = pc, imem_rw_enable = read issued this cycle,
//            imem_data_in tied to zero, imem_data_out valid one cycle after issue;
//            instr/instr_pc/instr_valid to decode, popped on instr_valid & instr_ready;
//            redirect_valid/redirect_pc restart fetch and kill everything buffered.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                INSTR_W    = DEF_INSTR_W,
  parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC   = DEF_RESET_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_unit_if.master   bus
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  pc;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;

  logic               issue;
  logic               push;
  logic               pop;
  logic [CNT_W:0]     occupancy;

  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;

  // Credit check counts the in-flight read as occupied and ignores a pop in
  // the same cycle, so a response always has a free slot when it lands.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign issue     = !reset && !bus.redirect_valid &&
                     (occupancy < (CNT_W+1)'(FIFO_DEPTH));

  // A redirect kills the response of the read issued in the previous cycle.
  // The credit scheme means fifo_full never blocks a real response here.
  assign push = inflight && !bus.redirect_valid && !fifo_full;
  assign pop  = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      pc       <= bus.redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + ADDR_W'(1);
        inflight_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data ({inflight_pc, bus.imem_data_out}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_pc, head_instr} = fifo_head;

  assign bus.imem_address   = pc;
  assign bus.imem_rw_enable = issue;
  assign bus.imem_data_in   = '0;

  // Outputs read as zero whenever nothing valid is presented, including the
  // reset cycle itself.
  assign bus.instr_valid = !reset && !fifo_empty;
  assign bus.instr       = bus.instr_valid ? head_instr : '0;
  assign bus.instr_pc    = bus.instr_valid ? head_pc : '0;

endmodule
